// File: rtl/busarb_rr.sv
// ---------------------------------------------------------------------------
// busarb_rr: parked, round-robin arbiter for a shared bus.
//
// One master owns the bus at any time. The owner keeps it while it requests,
// and also while nobody else requests (parking). When the owner stops
// requesting and others are waiting, ownership rotates to the first
// requester found scanning own+1, own+2, ... (mod N_MASTERS).
//
// Request/grant handshake: breq_[i] low means master i wants the bus.
// bgrt_[i] low means master i owns the bus. Exactly one bgrt_ bit is low in
// every cycle. A request sampled low on an idle bus is granted at that edge,
// so the grant is visible one cycle after the request.
//
// Optional feature (macro BUSARB_TIMEOUT_EN): a hold counter limits how many
// consecutive contended edges an owner may keep the bus. After MAX_HOLD
// such edges, the next contended edge forces a handover.
//
// Ports:
//   clk       in   1          system clock, rising edge
//   reset_    in   1          asynchronous reset, active low
//   breq_     in   N_MASTERS  bus request per master, active low
//   bgrt_     out  N_MASTERS  bus grant per master, active low, one-hot-low
//   bgrt_idx  out  IDX_W      binary index of the current owner
//   bbusy     out  1          owner is currently requesting
// ---------------------------------------------------------------------------
module busarb_rr #(
  parameter int N_MASTERS = 4,
  parameter int IDX_W     = 2,
  parameter int PARK_IDX  = 0,
  parameter int MAX_HOLD  = 16
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic [N_MASTERS-1:0] breq_,
  output logic [N_MASTERS-1:0] bgrt_,
  output logic [IDX_W-1:0]     bgrt_idx,
  output logic                 bbusy
);

  // Owner register: the only arbitration state.
  logic [IDX_W-1:0] own;

  // First other requester in rotation order after the owner.
  logic [IDX_W-1:0] next_own;
  logic             other_req;

  always_comb begin
    int c;
    next_own  = own;
    other_req = 1'b0;
    c         = 0;
    for (int k = 1; k < N_MASTERS; k++) begin
      c = int'(own) + k;
      if (c >= N_MASTERS) c = c - N_MASTERS;
      if (!other_req && !breq_[IDX_W'(c)]) begin
        other_req = 1'b1;
        next_own  = IDX_W'(c);
      end
    end
  end

  // Grant decode depends only on the owner register, never on this cycle's
  // requests, so the grant cannot glitch with breq_.
  always_comb begin
    bgrt_      = '1;
    bgrt_[own] = 1'b0;
  end

  assign bgrt_idx = own;
  assign bbusy    = ~breq_[own];

`ifdef BUSARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  // Counts consecutive edges where the owner requests while someone else
  // waits. Any edge without contention, or any handover, clears it.
  logic [HOLD_W-1:0] hold;
  logic              contended;

  assign contended = bbusy && other_req;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      own  <= IDX_W'(PARK_IDX);
      hold <= '0;
    end else if (contended) begin
      if (hold == HOLD_W'(MAX_HOLD)) begin
        // Tenure exhausted: preempt the owner in favour of the next waiter.
        own  <= next_own;
        hold <= '0;
      end else begin
        hold <= hold + 1'b1;
      end
    end else begin
      hold <= '0;
      if (!bbusy && other_req) own <= next_own;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      own <= IDX_W'(PARK_IDX);
    end else if (!bbusy && other_req) begin
      own <= next_own;
    end
  end
`endif

endmodule

// File: tb/tb_busarb_rr.sv
// ---------------------------------------------------------------------------
// tb_busarb_rr: directed self-checking bench for busarb_rr
// (N_MASTERS=4, PARK_IDX=0, MAX_HOLD=4). Inputs change #1 after the rising
// edge and outputs are compared at that point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_busarb_rr;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk;
  logic          reset_;
  logic [N-1:0]  breq_;
  logic [N-1:0]  bgrt_;
  logic [IW-1:0] bgrt_idx;
  logic          bbusy;

  int n_cmp = 0;
  int n_err = 0;

  // Expected owner sequence for the rotation test.
  logic [IW-1:0] exp_q[$];

  busarb_rr #(
    .N_MASTERS (N),
    .IDX_W     (IW),
    .PARK_IDX  (0),
    .MAX_HOLD  (4)
  ) dut (
    .clk      (clk),
    .reset_   (reset_),
    .breq_    (breq_),
    .bgrt_    (bgrt_),
    .bgrt_idx (bgrt_idx),
    .bbusy    (bbusy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full grant check for an expected owner.
  task automatic check_owner(input string tag, input logic [IW-1:0] exp_idx);
    logic [N-1:0] exp_g;
    exp_g          = '1;
    exp_g[exp_idx] = 1'b0;
    check_eq({tag, "_idx"}, 32'(bgrt_idx), 32'(exp_idx));
    check_eq({tag, "_grt"}, 32'(bgrt_), 32'(exp_g));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [IW-1:0] e;

    // Test 1: asynchronous reset, then idle park.
    reset_ = 1'b0;
    breq_  = 4'b0000;
    #2;
    check_owner("t1_async_rst", 2'd0);
    tick();
    breq_  = 4'b1111;
    reset_ = 1'b1;
    ticks(3);
    check_owner("t1_idle_park", 2'd0);
    check_eq("t1_bbusy", 32'(bbusy), 32'd0);

    // Test 2: masters 1 and 3 request, owner 0 idle.
    breq_ = 4'b0101;
    #1;
    check_eq("t2_bbusy_pre", 32'(bbusy), 32'd0);
    check_owner("t2_no_early_grant", 2'd0);
    tick();
    check_owner("t2_to1", 2'd1);
    check_eq("t2_bbusy1", 32'(bbusy), 32'd1);
    breq_ = 4'b0111;
    tick();
    check_owner("t2_to3", 2'd3);
    breq_ = 4'b1111;
    ticks(3);
    check_owner("t2_park3", 2'd3);

    // Test 3: wrap from 3 to 0, then 0 releases to 2.
    breq_ = 4'b1010;
    tick();
    check_owner("t3_wrap0", 2'd0);
    breq_ = 4'b1011;
    tick();
    check_owner("t3_to2", 2'd2);

    // Test 4: owner 1 holds against master 2.
    breq_ = 4'b1101;
    tick();
    check_owner("t4_to1", 2'd1);
    breq_ = 4'b1001;
`ifdef BUSARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      check_owner("t4_hold", 2'd1);
    end
    tick();
    check_owner("t4_preempt", 2'd2);
    check_eq("t4_hold_cleared", 32'(dut.hold), 32'd0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      check_eq("t4_hold_idx", 32'(bgrt_idx), 32'd1);
      check_eq("t4_hold_busy", 32'(bbusy), 32'd1);
    end
`endif
    // Move ownership to 0 for the rotation test.
    breq_ = 4'b1110;
    tick();
    check_owner("t4_to0", 2'd0);

    // Test 5: everyone requests; the owner releases after one cycle.
    exp_q = {2'd1, 2'd2, 2'd3, 2'd0};
    e = 2'd0;
    while (exp_q.size() != 0) begin
      breq_ = 4'b0001 << e;
      tick();
      e = exp_q.pop_front();
      check_owner("t5_rot", e);
      check_eq("t5_onehot", 32'($countones(~bgrt_)), 32'd1);
    end

    // Test 6: owner 2 requesting, reset pulsed mid-cycle.
    breq_ = 4'b1011;
    tick();
    check_owner("t6_to2", 2'd2);
    #2;
    reset_ = 1'b0;
    #1;
    check_owner("t6_async_rst", 2'd0);
    check_eq("t6_bbusy_rst", 32'(bbusy), 32'd0);
    reset_ = 1'b1;
    tick();
    check_owner("t6_back2", 2'd2);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
